// File: rtl/sample_stream_pkg.sv
// Shared types and helpers for the sample stream FIFO.
// Pointer width helper, default pointer type, default counter width.
package sample_stream_pkg;

  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_COUNT_WIDTH = 16;

  // Pointer carries one extra MSB to tell full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [ptr_width(DEFAULT_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/sample_stream_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, async read, no reset.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module sample_stream_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sample_stream_fifo.sv
// First-word-fall-through valid/ready FIFO with flush, level,
// almost_full and a wrapping output-handshake counter.
// Ports: clk, rst, flush, stream_in_*, stream_out_*, level,
// almost_full, xfer_count.
module sample_stream_fifo
  import sample_stream_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int DEPTH             = 4,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
  parameter int COUNT_WIDTH       = DEFAULT_COUNT_WIDTH,
  localparam int LW               = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stream_in_valid,
  output logic                   stream_in_ready,
  input  logic [DATA_WIDTH-1:0]  stream_in_data,
  output logic                   stream_out_valid,
  input  logic                   stream_out_ready,
  output logic [DATA_WIDTH-1:0]  stream_out_data,
  output logic [LW-1:0]          level,
  output logic                   almost_full,
  output logic [COUNT_WIDTH-1:0] xfer_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [LW-1:0] AF_LVL = LW'(ALMOST_FULL_LEVEL);

  typedef logic [PW-1:0] fifo_ptr_t;

  fifo_ptr_t wr_ptr;
  fifo_ptr_t rd_ptr;
  logic      empty;
  logic      full;
  logic      push;
  logic      pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready never looks at stream_out_ready: no comb path through.
  assign stream_in_ready  = !full && !flush && !rst;
  assign stream_out_valid = !empty && !flush;

  assign push = stream_in_valid && stream_in_ready;
  assign pop  = stream_out_valid && stream_out_ready;

  assign level       = LW'(wr_ptr - rd_ptr);
  assign almost_full = (level >= AF_LVL);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      xfer_count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        xfer_count <= xfer_count + COUNT_WIDTH'(1);
      end
    end
  end

  sample_stream_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (stream_in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (stream_out_data)
  );

endmodule

// File: tb/tb_sample_stream_fifo.sv
// Bench for sample_stream_fifo: directed phases plus random traffic
// checked each cycle against a queue-based reference model.
module tb_sample_stream_fifo;

  localparam int DW  = 8;
  localparam int D   = 4;
  localparam int AFL = 3;
  localparam int CW  = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          stream_in_valid;
  logic          stream_in_ready;
  logic [DW-1:0] stream_in_data;
  logic          stream_out_valid;
  logic          stream_out_ready;
  logic [DW-1:0] stream_out_data;
  logic [2:0]    level;
  logic          almost_full;
  logic [CW-1:0] xfer_count;

  sample_stream_fifo #(
    .DATA_WIDTH        (DW),
    .DEPTH             (D),
    .ALMOST_FULL_LEVEL (AFL),
    .COUNT_WIDTH       (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .stream_in_valid  (stream_in_valid),
    .stream_in_ready  (stream_in_ready),
    .stream_in_data   (stream_in_data),
    .stream_out_valid (stream_out_valid),
    .stream_out_ready (stream_out_ready),
    .stream_out_data  (stream_out_data),
    .level            (level),
    .almost_full      (almost_full),
    .xfer_count       (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  logic [DW-1:0] q[$];
  int            pops;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check, model the edge.
  task automatic cyc(input logic r, input logic f,
                     input logic iv, input logic [DW-1:0] d,
                     input logic ordy, input bit chk);
    bit e_rdy;
    bit e_vld;
    rst              = r;
    flush            = f;
    stream_in_valid  = iv;
    stream_in_data   = d;
    stream_out_ready = ordy;
    #1;
    e_rdy = !r && !f && (q.size() < D);
    e_vld = !f && (q.size() > 0);
    if (chk) begin
      check("in_ready", 32'(stream_in_ready), 32'(e_rdy));
      check("out_valid", 32'(stream_out_valid), 32'(e_vld));
      check("level", 32'(level), 32'(q.size()));
      check("almost_full", 32'(almost_full),
            32'(q.size() >= AFL));
      check("xfer_count", 32'(xfer_count), 32'(pops % (1 << CW)));
      if (e_vld)
        check("out_data", 32'(stream_out_data), 32'(q[0]));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      pops = 0;
    end else if (f) begin
      q.delete();
    end else begin
      if (e_vld && ordy) begin
        void'(q.pop_front());
        pops++;
      end
      if (iv && e_rdy) q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    pops  = 0;
    rst = 1'b1;
    flush = 1'b0;
    stream_in_valid = 1'b0;
    stream_in_data = '0;
    stream_out_ready = 1'b0;

    // Reset: pointers unknown before the first edge.
    cyc(1, 0, 0, 8'h00, 0, 0);
    cyc(1, 0, 0, 8'h00, 0, 1);
    cyc(0, 0, 0, 8'h00, 0, 1);

    // Fill then drain.
    for (int i = 1; i <= 4; i++)
      cyc(0, 0, 1, 8'(i * 8'h11), 0, 1);
    cyc(0, 0, 1, 8'h99, 0, 1);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, 8'h00, 1, 1);

    // Streaming.
    for (int i = 0; i < 100; i++)
      cyc(0, 0, 1, 8'(i), 1, 1);
    for (int i = 0; i < 2; i++)
      cyc(0, 0, 0, 8'h00, 1, 1);

    // Simultaneous push/pop at full.
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 1, 8'(8'hA0 + i), 0, 1);
    cyc(0, 0, 1, 8'h55, 1, 1);
    cyc(0, 0, 1, 8'h55, 0, 1);
    cyc(0, 0, 0, 8'h00, 0, 1);

    // Flush at level 3 with a beat offered.
    cyc(0, 0, 0, 8'h00, 1, 1);
    cyc(0, 0, 0, 8'h00, 0, 1);
    cyc(0, 1, 1, 8'h77, 1, 1);
    cyc(0, 0, 0, 8'h00, 1, 1);

    // Pointer wrap integrity: 3*DEPTH+1 beats with backpressure.
    for (int i = 0; i < 3 * D + 1; i++)
      cyc(0, 0, 1, 8'(8'hC0 + i), i[0], 1);
    for (int i = 0; i < D + 2; i++)
      cyc(0, 0, 0, 8'h00, 1, 1);

    // Reset mid-stream at level 2.
    cyc(0, 0, 1, 8'h12, 0, 1);
    cyc(0, 0, 1, 8'h34, 0, 1);
    cyc(1, 0, 1, 8'h56, 1, 1);
    cyc(0, 0, 1, 8'hA5, 0, 1);
    cyc(0, 0, 0, 8'h00, 1, 1);
    cyc(0, 0, 0, 8'h00, 1, 1);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 39) == 0,
          1'($urandom),
          8'($urandom),
          $urandom_range(0, 3) != 0,
          1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sample_stream_fifo.md
# sample_stream_fifo

Parametrised successor to the single-register stream path in the sample test designs. It is a first-word-fall-through FIFO between a valid/ready input stream and a valid/ready output stream. It adds configurable data width and depth, true backpressure on both sides, a synchronous flush, an occupancy level, an almost-full flag, and a wrapping transfer counter. It sits in the test-design tree as a cocotb target for handshake, backpressure and parameter-access tests.

## Interface
- DATA_WIDTH, 8: width of stream_in_data and stream_out_data; legal range ≥1.
- DEPTH, 4: number of entries; must be a power of two, ≥2.
- ALMOST_FULL_LEVEL, DEPTH-1: level at or above which almost_full asserts; legal range 1..DEPTH.
- COUNT_WIDTH, 16: width of xfer_count.
- clk  input  1  Single clock; all logic on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- flush  input  1  Synchronous clear of contents, sampled at the clock edge.
- stream_in_valid  input  1  Input beat offered.
- stream_in_ready  output  1  FIFO can accept a beat.
- stream_in_data  input  DATA_WIDTH  Input payload.
- stream_out_valid  output  1  Head entry available.
- stream_out_ready  input  1  Downstream accepts the head.
- stream_out_data  output  DATA_WIDTH  Head payload, first-word-fall-through.
- level  output  $clog2(DEPTH+1)  Current occupancy, 0..DEPTH.
- almost_full  output  1  Asserted when level ≥ ALMOST_FULL_LEVEL.
- xfer_count  output  COUNT_WIDTH  Count of completed output handshakes.

## Operation
- Push occurs when stream_in_valid && stream_in_ready at a clock edge. Pop occurs when stream_out_valid && stream_out_ready at a clock edge.
- stream_in_ready = !full && !flush. It has no combinational dependency on stream_out_ready.
- Consequence: when full, a simultaneous pop does not open the input in the same cycle.
- stream_out_valid = !empty && !flush.
- stream_out_data = storage[rd_ptr] at all times. Its value is don't-care when valid is low.
- Pointers are $clog2(DEPTH)+1 bits, with the extra MSB used for wrap.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
- level is computed as wr_ptr − rd_ptr. A simultaneous push and pop leaves level unchanged.
- Push while empty: the beat appears on the output in the next cycle. A pop in the same cycle is impossible because valid is low.
- Data must be held stable by the source while valid && !ready. The FIFO relies on this only for correctness of the test, not for internal state.
- flush = 1 at an edge:
  - rd_ptr and wr_ptr reset to 0 and level becomes 0.
  - No push and no pop occurs, because both ready and valid are forced low combinationally.
  - xfer_count is unchanged.
- xfer_count increments by 1 on every pop and wraps modulo 2^COUNT_WIDTH. It is not cleared by flush, only by rst.
- Reset values: level 0, stream_out_valid 0, stream_in_ready 1 (when rst and flush are low), almost_full 0, xfer_count 0.
  - stream_in_ready is 0 while rst is high.
  - Storage contents are not reset.
- Reset mid-operation discards all entries at that edge. Reset has priority over flush, which has priority over push and pop.

## Timing
- Latency from input to output: 1 cycle. A beat accepted at edge N is valid on the output after edge N.
- Steady-state throughput is 1 beat per cycle in each direction, provided the FIFO is neither empty nor full.
- level, almost_full, stream_out_valid and stream_in_ready all reflect state updated at the previous edge. No output changes between edges except through flush, whose effect on ready and valid is combinational.
- Minimum depth 2 is required for full throughput under continuous backpressure toggling.

## Structure
- The package sample_stream_pkg holds:
  - the typedef for the pointer type, parametrised through a function helper computing $clog2(DEPTH)+1;
  - a localparam for the default COUNT_WIDTH.
- Sub-module sample_stream_ram: DEPTH × DATA_WIDTH array with synchronous write and asynchronous read by address. It has no reset.
- Control, pointers, level and counter live in sample_stream_fifo.
- Parameter and port names match the above exactly, so cocotb handle lookup is stable.

## Test plan
- Fill and drain: DEPTH=4, DATA_WIDTH=8, out_ready=0. Push 0x11,0x22,0x33,0x44 → level 4, in_ready 0, almost_full 1 from level 3. Then out_ready=1 → out_data 0x11,0x22,0x33,0x44 on consecutive cycles, xfer_count 4, level 0.
- Streaming: valid and out_ready held at 1 for 100 beats with incrementing data → output equals input delayed 1 cycle, level stays ≤1, xfer_count 100.
- Simultaneous push/pop at full: level 4, in_valid=1, out_ready=1 → exactly one pop, no push (in_ready 0), level 3. The next cycle accepts the push.
- Flush: level 3 and flush pulsed for 1 cycle with in_valid=1 → in_ready and out_valid are 0 during the pulse, level 0 after the edge, no beat accepted, xfer_count unchanged.
- Wrap: COUNT_WIDTH=4, 17 pops → xfer_count 1. Pointer wrap is exercised with 3×DEPTH+1 beats and data integrity is checked.
- Reset mid-stream: rst asserted at level 2 → at the next edge level 0, out_valid 0, xfer_count 0, and the first post-reset beat comes out correctly.
